// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor D = A - B (mod 2^WIDTH), BOUT = borrow (A < B), LSB first.
// Latency WIDTH+1 cycles from accepted start to the done pulse; start is ignored while busy.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] D,
    output logic             BOUT,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, next_state;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] res_sh;
    logic [CW-1:0]    cnt;
    logic             br;

    logic             a0;
    logic             b0;
    logic             dbit;
    logic             br_next;
    logic             last;
    logic [WIDTH-1:0] res_next;

    assign a0       = a_sh[0];
    assign b0       = b_sh[0];
    assign dbit     = a0 ^ b0 ^ br;
    assign br_next  = (~a0 & b0) | (~(a0 ^ b0) & br);
    assign last     = (cnt == CW'(WIDTH - 1));
    // res_sh keeps only the WIDTH-1 most recent bits; the full word is formed on the final bit.
    assign res_next = {dbit, res_sh};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            cnt    <= '0;
            br     <= 1'b0;
            D      <= '0;
            BOUT   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh <= A;
                        b_sh <= B;
                        br   <= 1'b0;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    br     <= br_next;
                    cnt    <= cnt + 1'b1;
                    res_sh <= res_next[WIDTH-1:1];
                    // Outputs are only updated on the final bit so they hold stable between results.
                    if (last) begin
                        D    <= res_next;
                        BOUT <= br_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random self-checking bench for serial_subtractor at WIDTH=8.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] D;
    logic         BOUT;
    logic         busy;
    logic         done;

    int checks;
    int errors;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .D     (D),
        .BOUT  (BOUT),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launches one operation and waits (bounded) for done; lat = -1 on timeout.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] d, output logic bo,
                         output int lat, output int busy_cycles);
        A = a;
        B = b;
        start = 1'b1;
        step();
        start = 1'b0;
        busy_cycles = busy ? 1 : 0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (busy) busy_cycles++;
            if (done) begin
                lat = n;
                break;
            end
        end
        d  = D;
        bo = BOUT;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        A     = 8'hAA;
        B     = 8'h55;
        step();
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || D !== 8'h00 || BOUT !== 1'b0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b D=%h BOUT=%b required 0 0 00 0", busy, done, D, BOUT);
        end
        start = 1'b0;
        rst   = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || D !== 8'h00) begin
            errors++;
            $display("FAIL reset_release: busy=%b D=%h required 0 00", busy, D);
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] d;
        logic bo;
        int lat, bc;
        do_op(8'h5A, 8'h23, d, bo, lat, bc);
        checks++;
        if (d !== 8'h37 || bo !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: D=%h BOUT=%b required 37 0", d, bo);
        end
        checks++;
        if (lat !== 8) begin
            errors++;
            $display("FAIL basic_latency: done %0d edges after accept, required 8", lat);
        end
        checks++;
        if (bc !== 9) begin
            errors++;
            $display("FAIL basic_busy: busy for %0d cycles, required 9", bc);
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_pulse: done=%b busy=%b after DONE, required 0 0", done, busy);
        end
    endtask

    task automatic test_borrow();
        logic [W-1:0] va [3] = '{8'h10, 8'hFF, 8'h00};
        logic [W-1:0] vb [3] = '{8'h20, 8'hFF, 8'h01};
        logic [W-1:0] vd [3] = '{8'hF0, 8'h00, 8'hFF};
        logic         vo [3] = '{1'b1, 1'b0, 1'b1};
        logic [W-1:0] d;
        logic bo;
        int lat, bc;
        for (int i = 0; i < 3; i++) begin
            do_op(va[i], vb[i], d, bo, lat, bc);
            step();
            checks++;
            if (d !== vd[i] || bo !== vo[i] || lat !== 8) begin
                errors++;
                $display("FAIL borrow_vec%0d: D=%h BOUT=%b lat=%0d required %h %b 8",
                         i, d, bo, lat, vd[i], vo[i]);
            end
        end
    endtask

    task automatic test_hold_and_isolation();
        logic [W-1:0] d;
        logic bo;
        int lat, bc;
        // Operands change during RUN and a second start arrives mid-operation.
        A = 8'h80;
        B = 8'h01;
        start = 1'b1;
        step();
        start = 1'b0;
        A = 8'h00;
        B = 8'hFF;
        step();
        step();
        start = 1'b1;
        A = 8'h11;
        B = 8'h22;
        step();
        start = 1'b0;
        lat = -1;
        for (int n = 4; n <= 40; n++) begin
            step();
            if (done) begin
                lat = n;
                break;
            end
        end
        checks++;
        if (D !== 8'h7F || BOUT !== 1'b0 || lat !== 8) begin
            errors++;
            $display("FAIL isolation: D=%h BOUT=%b lat=%0d required 7F 0 8", D, BOUT, lat);
        end
        // Result must hold through IDLE while inputs wiggle without start.
        A = 8'h33;
        B = 8'h99;
        for (int n = 0; n < 5; n++) step();
        checks++;
        if (D !== 8'h7F || BOUT !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL hold: D=%h BOUT=%b busy=%b done=%b required 7F 0 0 0", D, BOUT, busy, done);
        end
        do_op(8'h01, 8'h02, d, bo, lat, bc);
        step();
        checks++;
        if (d !== 8'hFF || bo !== 1'b1) begin
            errors++;
            $display("FAIL after_isolation: D=%h BOUT=%b required FF 1", d, bo);
        end
    endtask

    task automatic test_back_to_back();
        int dones;
        logic [W-1:0] exp_d;
        logic exp_b;
        logic [W-1:0] fa, fb;
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            A = W'(i * 7 + 3);
            B = W'(i * 13 + 1);
            start = 1'b1;
            step();
            checks++;
            if (done !== ((i % 10) == 8)) begin
                errors++;
                $display("FAIL b2b_done_cycle%0d: done=%b required %b", i, done, (i % 10) == 8);
            end
            if (done) begin
                dones++;
                fa = W'((i - 8) * 7 + 3);
                fb = W'((i - 8) * 13 + 1);
                exp_d = fa - fb;
                exp_b = (fa < fb);
                checks++;
                if (D !== exp_d || BOUT !== exp_b) begin
                    errors++;
                    $display("FAIL b2b_result_cycle%0d: D=%h BOUT=%b required %h %b", i, D, BOUT, exp_d, exp_b);
                end
            end
        end
        start = 1'b0;
        checks++;
        if (dones !== 3) begin
            errors++;
            $display("FAIL b2b_count: %0d done pulses, required 3", dones);
        end
        // Let the operation accepted at cycle 20 finish.
        for (int n = 0; n < 12; n++) step();
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] d;
        logic bo;
        int lat, bc;
        int seen;
        A = 8'hC3;
        B = 8'h01;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 0; n < 3; n++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || D !== 8'h00 || BOUT !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: busy=%b D=%h BOUT=%b done=%b required 0 00 0 0", busy, D, BOUT, done);
        end
        seen = 0;
        for (int n = 0; n < 12; n++) begin
            step();
            if (done || busy) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL mid_reset_abort: %0d busy/done cycles after abort, required 0", seen);
        end
        do_op(8'h33, 8'h44, d, bo, lat, bc);
        step();
        checks++;
        if (d !== 8'hEF || bo !== 1'b1 || lat !== 8) begin
            errors++;
            $display("FAIL post_reset_op: D=%h BOUT=%b lat=%0d required EF 1 8", d, bo, lat);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, d, exp_d;
        logic bo, exp_b;
        int lat, bc;
        for (int i = 0; i < 1000; i++) begin
            a = W'($urandom_range(255, 0));
            b = W'($urandom_range(255, 0));
            exp_d = a - b;
            exp_b = (a < b);
            do_op(a, b, d, bo, lat, bc);
            step();
            checks++;
            if (d !== exp_d || bo !== exp_b || lat !== 8 || bc !== 9) begin
                errors++;
                $display("FAIL random%0d %h-%h: D=%h BOUT=%b lat=%0d busy=%0d required %h %b 8 9",
                         i, a, b, d, bo, lat, bc, exp_d, exp_b);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        start  = 1'b0;
        A      = '0;
        B      = '0;
        test_reset();
        test_basic();
        test_borrow();
        test_hold_and_isolation();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; SHALL be >= 2.
REQ-002 Port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1, reset; SHALL be synchronous and active-high.
REQ-004 Port start, input, 1, request to begin a subtraction; sampled on the clk rising edge.
REQ-005 Port A, input, WIDTH, minuend; sampled only on an accepted start.
REQ-006 Port B, input, WIDTH, subtrahend; sampled only on an accepted start.
REQ-007 Port D, output, WIDTH, difference A-B modulo 2^WIDTH.
REQ-008 Port BOUT, output, 1, final borrow; 1 when A < B unsigned.
REQ-009 Port busy, output, 1, high while an operation is in progress.
REQ-010 Port done, output, 1, single-cycle pulse marking D/BOUT valid.

Function
REQ-011 FSM states SHALL be IDLE, RUN, DONE; encoding is free.
REQ-012 IDLE: start=1 SHALL be accepted. On that edge: latch A and B into shift registers, clear borrow register, clear bit counter, go to RUN.
REQ-013 RUN: each cycle, process the LSB of each operand register (a0, b0) with borrow register br.
REQ-014 Difference bit = a0 XOR b0 XOR br.
REQ-015 Next br = (NOT a0 AND b0) OR (NOT (a0 XOR b0) AND br).
REQ-016 Both operand registers SHALL shift right by one bit each RUN cycle.
REQ-017 Each difference bit SHALL shift into the MSB of the result register, so that after WIDTH bits bit 0 is in D[0].
REQ-018 The counter SHALL increment each RUN cycle. After the WIDTH-th bit (counter = WIDTH-1), the FSM SHALL go to DONE.
REQ-019 On entry to DONE: D SHALL hold the full result and BOUT the final borrow.
REQ-020 done SHALL be 1 for exactly the one cycle in DONE. DONE SHALL go to IDLE unconditionally on the next edge.
REQ-021 Latency: start accepted at edge k; done SHALL be high in the cycle following edge k+WIDTH, which is WIDTH+1 cycles after acceptance.
REQ-022 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-023 start while busy=1 SHALL be ignored: no effect on operands, counter or result.
REQ-024 Back-to-back operation: start asserted in the cycle done is high SHALL be ignored. start in the following IDLE cycle SHALL be accepted.
REQ-025 D and BOUT SHALL change only on entry to DONE, or on reset. They SHALL hold their value through IDLE until the next result.
REQ-026 Changes on A and B after acceptance SHALL NOT affect the result in progress.
REQ-027 Arithmetic SHALL be unsigned and wrap modulo 2^WIDTH. No overflow flag beyond BOUT.

Reset
REQ-028 With rst=1 at a clk edge, the block SHALL enter IDLE and clear D, BOUT, busy, done, counter, borrow and operand registers to 0.
REQ-029 rst SHALL take priority over start and over any in-progress operation. A reset mid-RUN SHALL abort with no done pulse.
REQ-030 Outputs SHALL be 0 from the first edge with rst=1 until the next accepted operation completes.

Verification (WIDTH=8)
REQ-031 A=0x5A, B=0x23, start one cycle -> done high 9 cycles after the accepting edge, D=0x37, BOUT=0, busy high for the 9 cycles.
REQ-032 A=0x10, B=0x20 -> D=0xF0, BOUT=1.
REQ-033 A=0xFF, B=0xFF -> D=0x00, BOUT=0. A=0x00, B=0x01 -> D=0xFF, BOUT=1.
REQ-034 start held high continuously, with A/B changed every cycle -> only the values at each IDLE-cycle acceptance are used; exactly one done per 10 cycles.
REQ-035 rst=1 at cycle 4 of RUN -> next cycle busy=0, D=0x00, BOUT=0, no done pulse. A subsequent start computes correctly.
REQ-036 Random sweep of 1000 operand pairs vs. a reference model, checking D, BOUT and done timing.
